// File: rtl/col2im_pkg.sv
// col2im_pkg: shared fixed-point width, job state encoding and saturating add
// for the col2im/im2col/GEMM accumulator family.
package col2im_pkg;
    localparam int DEF_IL = 4;
    localparam int DEF_FL = 16;
    localparam int DATA_W = DEF_IL + DEF_FL;

    typedef enum logic [2:0] {IDLE, CHECK, CLEAR, ACCUM, DRAIN, DONE} state_t;

    // Sum at DATA_W+1 bits; differing top two bits mean the result left the range.
    function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] a,
                                                         input logic signed [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        return (s[DATA_W] != s[DATA_W-1]) ?
               (s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}}) :
               s[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/col2im_addr_gen.sv
// col2im_addr_gen: walks patches (oy,ox) and elements (kr,kc) row-major and
// produces the image-buffer target address using only additions.
module col2im_addr_gen #(
    parameter int HW = 7,
    parameter int WW = 7,
    parameter int KW = 5,
    parameter int AW = 12
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    input  logic          adv,
    input  logic [HW-1:0] im_h,
    input  logic [WW-1:0] im_w,
    input  logic [KW-1:0] k_h,
    input  logic [KW-1:0] k_w,
    input  logic [KW-1:0] stride,
    input  logic [AW-1:0] sw,
    output logic [AW-1:0] addr,
    output logic          last
);
    logic [KW-1:0] kc, kr;
    logic [WW-1:0] xbase;
    logic [HW-1:0] prow;
    logic [AW-1:0] rbase, ybase;
    logic          kc_end, kr_end, x_end, y_end;

    // A patch column/row is the last one when the next stride step would overrun the image.
    assign kc_end = kc == KW'(k_w - 1'b1);
    assign kr_end = kr == KW'(k_h - 1'b1);
    assign x_end  = int'(xbase) + int'(stride) + int'(k_w) > int'(im_w);
    assign y_end  = int'(prow) + int'(stride) + int'(k_h) > int'(im_h);
    assign last   = kc_end && kr_end && x_end && y_end;
    assign addr   = ybase + rbase + AW'(xbase) + AW'(kc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || init) begin
            kc    <= '0;
            kr    <= '0;
            xbase <= '0;
            prow  <= '0;
            rbase <= '0;
            ybase <= '0;
        end else if (adv) begin
            if (!kc_end) begin
                kc <= kc + 1'b1;
            end else begin
                kc <= '0;
                if (!kr_end) begin
                    kr    <= kr + 1'b1;
                    rbase <= rbase + AW'(im_w);
                end else begin
                    kr    <= '0;
                    rbase <= '0;
                    if (!x_end) begin
                        xbase <= xbase + WW'(stride);
                    end else begin
                        xbase <= '0;
                        prow  <= prow + HW'(stride);
                        ybase <= ybase + sw;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/col2im.sv
// col2im: overlap-adds a stream of k_h x k_w patches into an image buffer with
// saturation, then streams the reconstructed image out row-major.
module col2im
    import col2im_pkg::*;
#(
    parameter int IL = DEF_IL,
    parameter int FL = DEF_FL,
    parameter int h  = 64,
    parameter int w  = 64,
    parameter int k  = 16
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [$clog2(h+1)-1:0]         im_h,
    input  logic [$clog2(w+1)-1:0]         im_w,
    input  logic [$clog2(k+1)-1:0]         k_h,
    input  logic [$clog2(k+1)-1:0]         k_w,
    input  logic [$clog2(k+1)-1:0]         stride,
    input  logic                           start,
    input  logic signed [IL+FL-1:0]        in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [IL+FL-1:0]        out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done,
    output logic                           error
);
    localparam int HW = $clog2(h+1);
    localparam int WW = $clog2(w+1);
    localparam int KW = $clog2(k+1);
    localparam int AW = $clog2(h*w);
    localparam int DW = IL + FL;

    state_t               state, state_n;
    logic [HW-1:0]        im_h_r;
    logic [WW-1:0]        im_w_r;
    logic [KW-1:0]        k_h_r, k_w_r, stride_r;
    logic [AW-1:0]        cnt, sw, npix_m1, ag_addr, waddr;
    logic                 ag_last, bad, we, err_r;
    logic signed [DW-1:0] wdata;
    logic signed [DW-1:0] mem [h*w];

    assign bad = stride_r == '0 || k_h_r == '0 || k_w_r == '0 || im_h_r == '0 || im_w_r == '0 ||
                 int'(k_h_r) > int'(im_h_r) || int'(k_w_r) > int'(im_w_r);

    col2im_addr_gen #(.HW(HW), .WW(WW), .KW(KW), .AW(AW)) u_addr_gen (
        .clk(clk), .reset(reset), .init(state == CHECK), .adv(in_ready && in_valid),
        .im_h(im_h_r), .im_w(im_w_r), .k_h(k_h_r), .k_w(k_w_r), .stride(stride_r), .sw(sw),
        .addr(ag_addr), .last(ag_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? CHECK : IDLE;
            CHECK:   state_n = bad ? DONE : CLEAR;
            CLEAR:   state_n = cnt == npix_m1 ? ACCUM : CLEAR;
            ACCUM:   state_n = in_valid && ag_last ? DRAIN : ACCUM;
            DRAIN:   state_n = out_ready && out_last ? DONE : DRAIN;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = state == ACCUM;
    assign out_valid = state == DRAIN;
    assign out_last  = out_valid && cnt == npix_m1;
    assign out_data  = out_valid ? mem[cnt] : '0;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign error     = err_r;

    // CLEAR zero-fills and ACCUM read-modify-writes through the same single write port.
    assign we    = state == CLEAR || (in_ready && in_valid);
    assign waddr = state == CLEAR ? cnt : ag_addr;
    assign wdata = state == CLEAR ? '0 : sat_add(mem[ag_addr], in_data);

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_h_r   <= '0;
            im_w_r   <= '0;
            k_h_r    <= '0;
            k_w_r    <= '0;
            stride_r <= '0;
            err_r    <= 1'b0;
            cnt      <= '0;
            sw       <= '0;
            npix_m1  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    im_h_r   <= im_h;
                    im_w_r   <= im_w;
                    k_h_r    <= k_h;
                    k_w_r    <= k_w;
                    stride_r <= stride;
                    err_r    <= 1'b0;
                end
                CHECK: begin
                    err_r   <= bad;
                    cnt     <= '0;
                    sw      <= AW'(stride_r) * AW'(im_w_r);
                    npix_m1 <= AW'(im_h_r) * AW'(im_w_r) - 1'b1;
                end
                CLEAR: cnt <= cnt == npix_m1 ? '0 : cnt + 1'b1;
                DRAIN: if (out_ready) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_col2im.sv
// tb_col2im: table-driven directed jobs plus hand-written reject and reset sequences.
module tb_col2im;
    localparam int DW = 20;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [6:0]           im_h = '0, im_w = '0;
    logic [4:0]           k_h = '0, k_w = '0, stride = '0;
    logic                 start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic signed [DW-1:0] out_data;
    logic                 in_ready, out_valid, out_last, busy, done, error;

    int nchk = 0;
    int nfail = 0;

    typedef struct {
        int ih, iw, kh, kw, st, nin, nout, tog, per;
    } vec_t;
    vec_t tab[8];

    int din [8][16] = '{
        '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,16},
        '{'h10000,'h10000,'h10000,'h10000,'h10000,'h10000,'h10000,'h10000,
          'h10000,'h10000,'h10000,'h10000,'h10000,'h10000,'h10000,'h10000},
        '{'h40000,'h40000,'h40000,'h40000,0,0,0,0,0,0,0,0,0,0,0,0},
        '{'hA0000,'hA0000,'hA0000,'hA0000,0,0,0,0,0,0,0,0,0,0,0,0},
        '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,16},
        '{1,2,3,4,0,0,0,0,0,0,0,0,0,0,0,0},
        '{1,2,3,4,5,6,7,8,0,0,0,0,0,0,0,0},
        '{5,'hFFFFD,7,9,0,0,0,0,0,0,0,0,0,0,0,0}
    };
    int dout [8][16] = '{
        '{1,2,5,6,3,4,7,8,9,10,13,14,11,12,15,16},
        '{'h10000,'h20000,'h10000,'h20000,'h40000,'h20000,'h10000,'h20000,'h10000,0,0,0,0,0,0,0},
        '{'h40000,'h7FFFF,'h40000,0,0,0,0,0,0,0,0,0,0,0,0,0},
        '{'hA0000,'h80000,'hA0000,0,0,0,0,0,0,0,0,0,0,0,0,0},
        '{1,2,5,6,3,4,7,8,9,10,13,14,11,12,15,16},
        '{1,0,2,0,0,0,3,0,4,0,0,0,0,0,0,0},
        '{1,7,6,3,11,8,0,0,0,0,0,0,0,0,0,0},
        '{5,'hFFFFD,7,9,0,0,0,0,0,0,0,0,0,0,0,0}
    };

    col2im dut (
        .clk(clk), .reset(reset), .im_h(im_h), .im_w(im_w), .k_h(k_h), .k_w(k_w),
        .stride(stride), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int ih, input int iw, input int kh, input int kw, input int st);
        im_h = 7'(ih); im_w = 7'(iw); k_h = 5'(kh); k_w = 5'(kw); stride = 5'(st);
        start = 1'b1;
        tick();
        start = 1'b0;
        im_h = '0; im_w = '0; k_h = '0; k_w = '0; stride = '0;
        chk("busy_after_start", 32'(busy), 1);
    endtask

    task automatic feed(input int v, input int n);
        int i = 0;
        int cyc = 0;
        logic fire;
        while (i < n && cyc < 500) begin
            in_valid = tab[v].tog != 0 ? 1'(cyc % 2) : 1'b1;
            in_data  = DW'(din[v][i]);
            fire = in_valid && in_ready;
            tick();
            cyc++;
            if (fire) i++;
        end
        in_valid = 1'b0;
        chk($sformatf("v%0d_feed_count", v), 32'(i), 32'(n));
    endtask

    task automatic drain(input int v);
        int j = 0;
        int cyc = 0;
        logic fire;
        while (j < tab[v].nout && cyc < 500) begin
            out_ready = (cyc % tab[v].per) == 0;
            fire = out_valid && out_ready;
            if (out_valid) begin
                chk($sformatf("v%0d_data%0d", v, j), 32'(out_data), 32'(DW'(dout[v][j])));
                chk($sformatf("v%0d_last%0d", v, j), 32'(out_last), 32'(j == tab[v].nout - 1));
            end
            tick();
            cyc++;
            if (fire) j++;
        end
        out_ready = 1'b0;
        chk($sformatf("v%0d_drain_count", v), 32'(j), 32'(tab[v].nout));
        chk($sformatf("v%0d_done_pulse", v), 32'(done), 1);
        chk($sformatf("v%0d_no_valid_in_done", v), 32'(out_valid), 0);
        chk($sformatf("v%0d_no_error", v), 32'(error), 0);
        tick();
        chk($sformatf("v%0d_done_cleared", v), 32'(done), 0);
        chk($sformatf("v%0d_idle", v), 32'(busy), 0);
    endtask

    task automatic run_job(input int v);
        launch(tab[v].ih, tab[v].iw, tab[v].kh, tab[v].kw, tab[v].st);
        feed(v, tab[v].nin);
        chk($sformatf("v%0d_in_ready_drop", v), 32'(in_ready), 0);
        drain(v);
    endtask

    task automatic bad_job(input string name, input int ih, input int iw, input int kh,
                           input int kw, input int st);
        launch(ih, iw, kh, kw, st);
        chk({name, "_no_done_check"}, 32'(done), 0);
        tick();
        chk({name, "_done"}, 32'(done), 1);
        chk({name, "_error"}, 32'(error), 1);
        chk({name, "_no_valid"}, 32'(out_valid), 0);
        tick();
        chk({name, "_done_cleared"}, 32'(done), 0);
        chk({name, "_idle"}, 32'(busy), 0);
        chk({name, "_error_sticky"}, 32'(error), 1);
    endtask

    task automatic reset_outputs(input string name);
        chk({name, "_in_ready"}, 32'(in_ready), 0);
        chk({name, "_out_valid"}, 32'(out_valid), 0);
        chk({name, "_out_last"}, 32'(out_last), 0);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_done"}, 32'(done), 0);
        chk({name, "_error"}, 32'(error), 0);
        chk({name, "_out_data"}, 32'(out_data), 0);
    endtask

    initial begin
        tab[0] = '{4, 4, 2, 2, 2, 16, 16, 0, 1};
        tab[1] = '{3, 3, 2, 2, 1, 16, 9, 0, 1};
        tab[2] = '{3, 1, 2, 1, 1, 4, 3, 0, 1};
        tab[3] = '{3, 1, 2, 1, 1, 4, 3, 0, 1};
        tab[4] = '{4, 4, 2, 2, 2, 16, 16, 1, 3};
        tab[5] = '{3, 3, 1, 1, 2, 4, 9, 0, 1};
        tab[6] = '{2, 3, 2, 2, 1, 8, 6, 0, 1};
        tab[7] = '{2, 2, 1, 1, 1, 4, 4, 0, 1};

        tick();
        tick();
        reset_outputs("por");
        reset = 1'b1;
        tick();

        bad_job("stride0", 4, 4, 2, 2, 0);
        bad_job("kh_gt_imh", 2, 2, 3, 1, 1);

        for (int v = 0; v < 7; v++) run_job(v);

        launch(4, 4, 2, 2, 2);
        feed(0, 5);
        chk("mid_accum_ready", 32'(in_ready), 1);
        #2;
        reset = 1'b0;
        #1;
        reset_outputs("mid_reset");
        tick();
        reset_outputs("mid_reset_held");
        reset = 1'b1;
        tick();
        reset_outputs("after_release");
        run_job(7);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/col2im.md
Name: col2im

Overview:
- Inverse of the GEMM-side im2col unpacker: consumes a stream of k_h x k_w patches (GEMM output columns) and overlap-adds them back into an im_h x im_w image buffer.
- Then streams the reconstructed image out row-major.
- Sits after the GEMM array for transposed-convolution and gradient (backprop) paths.
- Data format is signed fixed point, IL integer + FL fractional bits; accumulation saturates.

Parameters:
- IL, 4, integer bits of data word
- FL, 16, fractional bits of data word
- h, 64, max image height (sizes internal buffer)
- w, 64, max image width
- k, 16, max kernel side and max stride

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- im_h  in  $clog2(h+1)  image height, sampled on start
- im_w  in  $clog2(w+1)  image width, sampled on start
- k_h  in  $clog2(k+1)  kernel height, sampled on start
- k_w  in  $clog2(k+1)  kernel width, sampled on start
- stride  in  $clog2(k+1)  stride, sampled on start
- start  in  1  begin job, honoured only in IDLE
- in_data  in  IL+FL  signed patch element
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  IL+FL  signed image pixel
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_last  out  1  marks final pixel (im_h*im_w-1)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job end
- error  out  1  sticky per job: config rejected

Behaviour:
- Reset (reset=0, async): state=IDLE; in_ready, out_valid, out_last, busy, done, error all 0; counters 0. Buffer contents are don't-care because CLEAR rewrites them.
- Reset mid-job aborts immediately. No output follows until a new start.
- States: IDLE -> CHECK -> CLEAR -> ACCUM -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 latches the config and clears error; next state CHECK.
- CHECK (1 cycle): the config is rejected if stride=0, k_h=0, k_w=0, im_h=0, im_w=0, k_h>im_h, or k_w>im_w.
  - On reject: error=1, go to DONE.
  - Otherwise compute oh=(im_h-k_h)/stride+1 and ow=(im_w-k_w)/stride+1 and go to CLEAR.
- CLEAR: writes 0 to buffer addresses 0..im_h*im_w-1, one per cycle (im_h*im_w cycles), then ACCUM.
- ACCUM:
  - in_ready=1; an element transfers when in_valid && in_ready.
  - Input order: patch (oy,ox) row-major, and within a patch (kr,kc) row-major.
  - Target address = (oy*stride+kr)*im_w + (ox*stride+kc).
  - Read-modify-write in the same cycle: buf[addr] <= sat(buf[addr]+in_data).
  - sat clamps to [-2^(IL+FL-1), 2^(IL+FL-1)-1]; the sum is computed at IL+FL+1 bits.
  - Pixels not covered by any patch (stride > kernel) stay 0.
  - After element oh*ow*k_h*k_w-1: in_ready=0 the next cycle, go to DRAIN.
  - in_valid=0 stalls without side effects.
- DRAIN:
  - out_valid=1; out_data=buf[rd_addr], starting at rd_addr=0.
  - rd_addr advances on out_valid && out_ready.
  - out_data and out_last hold stable while out_ready=0.
  - out_last=1 when rd_addr=im_h*im_w-1; the transfer of that pixel moves to DONE.
- DONE: done=1 for exactly one cycle; busy=1; next IDLE.
- start outside IDLE is ignored.
- Config inputs may change freely after start is accepted.

Decomposition:
- Shared package col2im_pkg:
  - DATA_W=IL+FL
  - state enum (IDLE, CHECK, CLEAR, ACCUM, DRAIN, DONE)
  - function sat_add(a,b) returning the saturated DATA_W result
- Package is reusable by im2col and the GEMM accumulators.
- Sub-module col2im_addr_gen: nested oy/ox/kr/kc counters with an advance input.
  - Outputs the target address and a last flag.
  - Registered counters; one multiply-free update per advance, with incremental row/column bases.

Test Plan:
- Non-overlap: im 4x4, k 2x2, stride 2, inputs 1..16 (patches row-major) -> out row-major 1,2,5,6,3,4,7,8,9,10,13,14,11,12,15,16; out_last on 16th; done pulse 1 cycle later.
- Overlap count: im 3x3, k 2x2, stride 1, all inputs 1.0 (0x10000) -> out 1,2,1,2,4,2,1,2,1 (x0x10000).
- Saturation: im 2x2, k 1x1... use im 2x1, k 1x1, stride 1 fed twice per pixel via im 2x2, k 2x1, stride... simpler: im 3x1, k 2x1, stride 1, inputs 0x40000 each (4 elems) -> middle pixel 0x7FFFF, ends 0x40000.
- Handshake: non-overlap case with in_valid toggling every other cycle and out_ready asserted 1-of-3 cycles -> identical output sequence; out_data stable while stalled.
- Bad config: stride=0 with start -> error=1, done pulse 2 cycles after start, no out_valid.
- Reset mid-ACCUM: assert reset after 5 inputs -> all outputs 0 immediately; a new 2x2 k1 stride1 job then outputs its inputs exactly (no residue).
